fifo_write_arbiter: RTL

FIFO_WRITE_ARBITER -- requirements
Module: fifo_write_arbiter

---
 rtl/fifo_write_arbiter_if.sv | 29 ++
 rtl/fifo_write_arbiter.sv | 110 +++++++++++
 2 files changed

// File: rtl/fifo_write_arbiter_if.sv
// Write-port bundle shared by the requesters, the arbiter and the downstream FIFO.
// The master side is the arbiter itself; the slave side is the requesters plus the FIFO.
interface fifo_write_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 32
);
  localparam int GW = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]            req_last;
  logic [NUM_REQ-1:0]            req_ready;
  logic                          fifo_full;
  logic                          fifo_almost_full;
  logic                          fifo_wr_en;
  logic [DATA_WIDTH-1:0]         fifo_wr_data;
  logic [GW-1:0]                 grant_id;
  logic                          busy;

  modport master (
    input  req_valid, req_data, req_last, fifo_full, fifo_almost_full,
    output req_ready, fifo_wr_en, fifo_wr_data, grant_id, busy
  );

  modport slave (
    output req_valid, req_data, req_last, fifo_full, fifo_almost_full,
    input  req_ready, fifo_wr_en, fifo_wr_data, grant_id, busy
  );
endinterface

// File: rtl/fifo_write_arbiter.sv
// Round-robin arbiter funnelling NUM_REQ beat streams into one FIFO write port.
// A grant lasts until a last beat or MAX_BURST beats; the write to the FIFO is registered.
module fifo_write_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_BURST  = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  fifo_write_arbiter_if.master bus
);
  localparam int GW = $clog2(NUM_REQ);
  localparam int CW = $clog2(MAX_BURST + 1);

  typedef enum logic {IDLE, BURST} state_t;

  state_t                state_q, state_d;
  logic [GW-1:0]         grant_q, grant_d;
  logic [GW-1:0]         rr_q, rr_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  wr_en_q, wr_en_d;
  logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;

  logic [DATA_WIDTH-1:0] req_data_arr [NUM_REQ];
  logic [NUM_REQ-1:0]    rot_valid;
  logic [GW-1:0]         offset;
  logic [GW:0]           sel_sum;
  logic [GW-1:0]         sel_id;
  logic [GW-1:0]         next_rr;
  logic                  can_write;
  logic                  accept;
  logic                  release_now;

  // Registered write leaves one beat in flight, so almost_full must stop the next accept.
  assign can_write = ~bus.fifo_full & ~bus.fifo_almost_full;

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
    assign req_data_arr[gi]  = bus.req_data[gi*DATA_WIDTH +: DATA_WIDTH];
    assign bus.req_ready[gi] = (state_q == BURST) && (grant_q == GW'(gi)) && can_write;
  end

  // Rotate valids so bit 0 is rr_q, take the lowest set bit, then undo the rotation.
  always_comb begin
    rot_valid = NUM_REQ'({bus.req_valid, bus.req_valid} >> rr_q);
    offset    = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (rot_valid[i]) offset = GW'(i);
    end
    sel_sum = {1'b0, rr_q} + {1'b0, offset};
    if (sel_sum >= (GW+1)'(NUM_REQ)) sel_sum = sel_sum - (GW+1)'(NUM_REQ);
    sel_id = GW'(sel_sum);
  end

  assign next_rr     = (grant_q == GW'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;
  assign accept      = (state_q == BURST) && bus.req_valid[grant_q] && can_write;
  assign release_now = bus.req_last[grant_q] || ((cnt_q + 1'b1) == CW'(MAX_BURST));

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    rr_d      = rr_q;
    cnt_d     = cnt_q;
    wr_en_d   = 1'b0;
    wr_data_d = wr_data_q;
    case (state_q)
      IDLE: begin
        if (|bus.req_valid) begin
          grant_d = sel_id;
          cnt_d   = '0;
          state_d = BURST;
        end
      end
      BURST: begin
        if (accept) begin
          wr_en_d   = 1'b1;
          wr_data_d = req_data_arr[grant_q];
          cnt_d     = cnt_q + 1'b1;
          if (release_now) begin
            state_d = IDLE;
            rr_d    = next_rr;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      grant_q   <= '0;
      rr_q      <= '0;
      cnt_q     <= '0;
      wr_en_q   <= 1'b0;
      wr_data_q <= '0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      rr_q      <= rr_d;
      cnt_q     <= cnt_d;
      wr_en_q   <= wr_en_d;
      wr_data_q <= wr_data_d;
    end
  end

  assign bus.fifo_wr_en   = wr_en_q;
  assign bus.fifo_wr_data = wr_data_q;
  assign bus.grant_id     = grant_q;
  assign bus.busy         = (state_q == BURST);
endmodule
